// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and shared-bus signals of the OAM DMA arbiter, grouped into one bundle.
// The slave modport is the arbiter's view; master is the surrounding CPU/bus environment.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw_n;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rw_n;
  logic        cpu_halt;
  logic        dma_busy;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_rw_n, bus_din,
    output bus_addr, bus_dout, bus_rw_n, cpu_halt, dma_busy
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_rw_n, bus_din,
    input  bus_addr, bus_dout, bus_rw_n, cpu_halt, dma_busy
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies a 256-byte page to the OAM data port.
// Define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when the HALT cycle lands on an odd cycle.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic              clk,
  input  logic              rst_n,
  oam_dma_arbiter_if.slave  sys
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  state;
  logic [7:0]  page;
  logic [7:0]  cnt;
  logic [7:0]  data_q;
  logic        cyc_odd;
  logic        trigger;
  logic [15:0] addr_mux;
  logic [7:0]  dout_mux;
  logic        rw_n_mux;

  // Triggers outside IDLE are dropped here, so page/cnt stay untouched mid-transfer.
  assign trigger = (state == S_IDLE) && !sys.cpu_rw_n && (sys.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      page    <= 8'h00;
      cnt     <= 8'h00;
      data_q  <= 8'h00;
      cyc_odd <= 1'b0;
    end else begin
      cyc_odd <= ~cyc_odd;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            page  <= sys.cpu_dout;
            cnt   <= 8'h00;
            state <= S_HALT;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          state <= cyc_odd ? S_ALIGN : S_READ;
`else
          state <= S_READ;
`endif
        end
        S_ALIGN: state <= S_READ;
        S_READ: begin
          data_q <= sys.bus_din;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          cnt   <= cnt + 8'h01;
          state <= (cnt == 8'hFF) ? S_IDLE : S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The CPU owns the bus only in IDLE; every other state drives a DMA cycle or an idle read.
  always_comb begin
    addr_mux = sys.cpu_addr;
    dout_mux = sys.cpu_dout;
    rw_n_mux = sys.cpu_rw_n;
    case (state)
      S_IDLE: begin
        addr_mux = sys.cpu_addr;
        dout_mux = sys.cpu_dout;
        rw_n_mux = sys.cpu_rw_n;
      end
      S_READ: begin
        addr_mux = {page, cnt};
        dout_mux = 8'h00;
        rw_n_mux = 1'b1;
      end
      S_WRITE: begin
        addr_mux = OAM_DATA_ADDR;
        dout_mux = data_q;
        rw_n_mux = 1'b0;
      end
      default: begin
        addr_mux = sys.cpu_addr;
        dout_mux = 8'h00;
        rw_n_mux = 1'b1;
      end
    endcase
  end

  assign sys.bus_addr = addr_mux;
  assign sys.bus_dout = dout_mux;
  assign sys.bus_rw_n = rw_n_mux;
  assign sys.cpu_halt = (state != S_IDLE);
  assign sys.dma_busy = (state != S_IDLE);

endmodule
